// File: rtl/ahb_fifo_slv.sv
// AHB-Lite slave bridging the bus to the FIR core through a TX FIFO and an RX FIFO.
// Optional wait-state timeout: define AHB_FIFO_TIMEOUT_EN.
module ahb_fifo_slv #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 32,
  parameter int DEPTH    = 8,
  parameter int WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  output logic [DWIDTH-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DWIDTH-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NQ  = 2;
  localparam int TXQ = 0;
  localparam int RXQ = 1;

  localparam logic [1:0] R_TX = 2'd0, R_RX = 2'd1, R_ST = 2'd2, R_CTRL = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;
  typedef struct packed {
    logic [1:0] sel;
    logic       write;
  } aph_t;

  state_t state, nxt;
  aph_t   aph_q;
  logic   accept, illegal, ready_cond, done, timeout, flush;
  logic [DWIDTH-1:0] status;
  logic [1:0] a_sel;

  logic [NQ-1:0]             q_push, q_pop, q_full, q_empty;
  logic [NQ-1:0][DWIDTH-1:0] q_wdata, q_head;
  logic [NQ-1:0][CW-1:0]     q_count;

  logic unused_ok;
  assign unused_ok = ^{haddr[AWIDTH-1:4], htrans[0]};

  // Both FIFOs share one implementation; only their hookup differs.
  for (genvar g = 0; g < NQ; g++) begin : g_q
    logic [DEPTH-1:0][DWIDTH-1:0] mem;
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp <= '0; rp <= '0; cnt <= '0;
      end else if (flush) begin
        wp <= '0; rp <= '0; cnt <= '0;
      end else begin
        if (q_push[g]) wp <= wp + 1'b1;
        if (q_pop[g])  rp <= rp + 1'b1;
        case ({q_push[g], q_pop[g]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk)
      if (q_push[g] && !flush) mem[wp] <= q_wdata[g];

    assign q_count[g] = cnt;
    assign q_full[g]  = (cnt == CW'(DEPTH));
    assign q_empty[g] = (cnt == '0);
    assign q_head[g]  = q_empty[g] ? '0 : mem[rp];
  end

  assign a_sel   = haddr[3:2];
  assign accept  = hsel & htrans[1] & hready;
  assign illegal = (hsize != 3'b010) || (haddr[1:0] != 2'b00) ||
                   (hwrite ? (a_sel == R_RX || a_sel == R_ST)
                           : (a_sel == R_TX || a_sel == R_CTRL));

  always_comb begin
    ready_cond = 1'b1;
    case (aph_q.sel)
      R_TX:    ready_cond = !q_full[TXQ];
      R_RX:    ready_cond = !q_empty[RXQ];
      default: ready_cond = 1'b1;
    endcase
  end

`ifdef AHB_FIFO_TIMEOUT_EN
  localparam int WCW = $clog2(WAIT_MAX);
  localparam logic [WCW-1:0] W_LAST = WCW'(WAIT_MAX - 1);
  logic [WCW-1:0] wait_cnt;
  assign timeout = (state == S_WAIT) && !ready_cond && (wait_cnt == W_LAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           wait_cnt <= '0;
    else if (state == S_WAIT && !ready_cond && !timeout) wait_cnt <= wait_cnt + 1'b1;
    else                                                  wait_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      aph_q <= '0;
    end else begin
      state <= nxt;
      if (accept) aph_q <= '{sel: a_sel, write: hwrite};
    end
  end

  always_comb begin
    nxt       = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (accept) nxt = illegal ? S_ERR1 : S_DATA;
      S_DATA, S_WAIT: begin
        if (ready_cond) begin
          done = 1'b1;
          nxt  = accept ? (illegal ? S_ERR1 : S_DATA) : S_IDLE;
        end else begin
          hreadyout = 1'b0;
          nxt       = timeout ? S_ERR1 : S_WAIT;
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        nxt       = S_ERR2;
      end
      S_ERR2: begin
        hresp = 1'b1;
        nxt   = accept ? (illegal ? S_ERR1 : S_DATA) : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Legal-only transfers reach DATA, so the register select alone identifies the action.
  assign flush          = done && aph_q.sel == R_CTRL && hwdata[0];
  assign q_push[TXQ]    = done && aph_q.sel == R_TX;
  assign q_wdata[TXQ]   = hwdata;
  assign q_pop[TXQ]     = tx_valid & tx_ready;
  assign q_push[RXQ]    = rx_valid & rx_ready;
  assign q_wdata[RXQ]   = rx_data;
  assign q_pop[RXQ]     = done && aph_q.sel == R_RX;

  assign tx_data  = q_head[TXQ];
  assign tx_valid = !q_empty[TXQ];
  assign rx_ready = !q_full[RXQ];

  always_comb begin
    status        = '0;
    status[3:0]   = {q_empty[RXQ], q_full[RXQ], q_empty[TXQ], q_full[TXQ]};
    status[11:8]  = 4'(q_count[TXQ]);
    status[19:16] = 4'(q_count[RXQ]);
    hrdata        = '0;
    if (done && !aph_q.write)
      hrdata = (aph_q.sel == R_RX) ? q_head[RXQ] : status;
  end
endmodule
